// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern mode encodings and 640x480@60 timing defaults.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GRAD  = 2'd3
    } vga_mode_e;

    localparam int VGA_CLK_DIV  = 4;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with active-area and sync decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP,
    parameter bit POL    = 1'b0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             active,
    output logic             sync
);

    localparam int               TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] count_reg;
    logic             in_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= wrap ? '0 : count_reg + CNT_W'(1);
        end
    end

    // wrap is the terminal-count flag; the caller qualifies it with its own enable
    assign wrap    = (count_reg == LAST);
    assign active  = (count_reg < ACT_END);
    assign in_sync = (count_reg >= SYNC_START) && (count_reg < SYNC_END);
    assign sync    = in_sync ? POL : ~POL;
    assign count   = count_reg;

endmodule

// File: rtl/vga_timing_core.sv
// VGA raster timing generator with built-in test patterns; all outputs are
// registered on the pixel strobe, one pixel behind the counters.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int COLOR_W  = 4,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] fg,
    output logic                 pix_en,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 video,
    output logic [CNT_W-1:0]     x,
    output logic [CNT_W-1:0]     y,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 frame_start
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam int               BAR_W    = H_ACTIVE / 8;

    logic [DIV_W-1:0] div_reg;
    logic             tick;

    assign tick = (div_reg == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg <= '0;
        end else begin
            div_reg <= tick ? '0 : div_reg + DIV_W'(1);
        end
    end

    logic [CNT_W-1:0] h_count, v_count;
    logic             h_wrap, h_active, h_sync;
    logic             v_wrap, v_active, v_sync;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .CNT_W(CNT_W)
    ) u_h_axis (
        .clk(clk), .rst(rst), .en(tick),
        .count(h_count), .wrap(h_wrap), .active(h_active), .sync(h_sync)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .CNT_W(CNT_W)
    ) u_v_axis (
        .clk(clk), .rst(rst), .en(tick & h_wrap),
        .count(v_count), .wrap(v_wrap), .active(v_active), .sync(v_sync)
    );

    logic      at_origin, vis;
    vga_mode_e frame_mode_reg, cur_mode;

    assign at_origin = (h_count == '0) && (v_count == '0);
    assign vis       = h_active & v_active;
    // The origin pixel already uses the mode being latched for the new frame
    assign cur_mode  = at_origin ? vga_mode_e'(mode) : frame_mode_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_mode_reg <= MODE_SOLID;
        end else if (tick && at_origin) begin
            frame_mode_reg <= vga_mode_e'(mode);
        end
    end

    // Bar index = number of bar boundaries at or left of h; the remainder lands in bar 7
    logic [6:0] bar_ge;
    logic [2:0] bar_idx, bar_code;

    for (genvar gi = 1; gi < 8; gi++) begin : g_bar_edge
        assign bar_ge[gi-1] = (h_count >= CNT_W'(gi * BAR_W));
    end

    assign bar_idx  = 3'($countones(bar_ge));
    assign bar_code = 3'd7 - bar_idx;

    logic [COLOR_W-1:0] red_next, green_next, blue_next;

    always_comb begin
        red_next   = '0;
        green_next = '0;
        blue_next  = '0;
        if (vis) begin
            case (cur_mode)
                MODE_SOLID: {red_next, green_next, blue_next} = fg;
                MODE_BARS: begin
                    red_next   = {COLOR_W{bar_code[2]}};
                    green_next = {COLOR_W{bar_code[1]}};
                    blue_next  = {COLOR_W{bar_code[0]}};
                end
                MODE_CHECK: begin
                    if (!(h_count[5] ^ v_count[5])) begin
                        {red_next, green_next, blue_next} = fg;
                    end
                end
                MODE_GRAD: begin
                    red_next   = COLOR_W'(h_count >> 3);
                    green_next = COLOR_W'(v_count >> 3);
                end
                default: ;
            endcase
        end
    end

    logic               pix_en_reg, frame_start_reg, video_reg, hsync_reg, vsync_reg;
    logic [CNT_W-1:0]   x_reg, y_reg;
    logic [COLOR_W-1:0] red_reg, green_reg, blue_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_en_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
            video_reg       <= 1'b0;
            hsync_reg       <= ~H_POL;
            vsync_reg       <= ~V_POL;
            x_reg           <= '0;
            y_reg           <= '0;
            red_reg         <= '0;
            green_reg       <= '0;
            blue_reg        <= '0;
        end else begin
            pix_en_reg      <= tick;
            frame_start_reg <= tick & at_origin;
            if (tick) begin
                video_reg <= vis;
                hsync_reg <= h_sync;
                vsync_reg <= v_sync;
                x_reg     <= vis ? h_count : '0;
                y_reg     <= vis ? v_count : '0;
                red_reg   <= red_next;
                green_reg <= green_next;
                blue_reg  <= blue_next;
            end
        end
    end

    assign pix_en      = pix_en_reg;
    assign frame_start = frame_start_reg;
    assign video       = video_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign x           = x_reg;
    assign y           = y_reg;
    assign red         = red_reg;
    assign green       = green_reg;
    assign blue        = blue_reg;

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed bench: default 640x480 instance, a tiny instance and a scaled-down frame instance.
module tb_vga_timing_core;
    import vga_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Instance A: full defaults
    logic        rst_a = 1'b1;
    logic [1:0]  mode_a = 2'd0;
    logic [11:0] fg_a = 12'h000;
    logic        pe_a, hs_a, vs_a, vid_a, fs_a;
    logic [15:0] x_a, y_a;
    logic [3:0]  r_a, g_a, b_a;

    vga_timing_core dut_a (
        .clk(clk), .rst(rst_a), .mode(mode_a), .fg(fg_a),
        .pix_en(pe_a), .hsync(hs_a), .vsync(vs_a), .video(vid_a),
        .x(x_a), .y(y_a), .red(r_a), .green(g_a), .blue(b_a), .frame_start(fs_a)
    );

    // Instance B: tiny raster, positive sync polarity, one clk per pixel
    logic        rst_b = 1'b1;
    logic [1:0]  mode_b = 2'd0;
    logic [11:0] fg_b = 12'h123;
    logic        pe_b, hs_b, vs_b, vid_b, fs_b;
    logic [15:0] x_b, y_b;
    logic [3:0]  r_b, g_b, b_b;

    vga_timing_core #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .mode(mode_b), .fg(fg_b),
        .pix_en(pe_b), .hsync(hs_b), .vsync(vs_b), .video(vid_b),
        .x(x_b), .y(y_b), .red(r_b), .green(g_b), .blue(b_b), .frame_start(fs_b)
    );

    // Instance C: scaled frame (80x48 total, 64x40 active) for multi-frame behaviour
    logic        rst_c = 1'b1;
    logic [1:0]  mode_c = 2'd0;
    logic [11:0] fg_c = 12'hA5C;
    logic        pe_c, hs_c, vs_c, vid_c, fs_c;
    logic [15:0] x_c, y_c;
    logic [3:0]  r_c, g_c, b_c;

    vga_timing_core #(
        .CLK_DIV(2), .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4)
    ) dut_c (
        .clk(clk), .rst(rst_c), .mode(mode_c), .fg(fg_c),
        .pix_en(pe_c), .hsync(hs_c), .vsync(vs_c), .video(vid_c),
        .x(x_c), .y(y_c), .red(r_c), .green(g_c), .blue(b_c), .frame_start(fs_c)
    );

    typedef struct {
        int h;
        int exp_rgb;
        int exp_video;
        int exp_hsync;
    } line_vec_t;

    typedef struct {
        int f;
        int h;
        int v;
        int exp_rgb;
    } frame_vec_t;

    line_vec_t  lv [16];
    frame_vec_t fv [12];

    int rgb_cap_a [800];
    int vid_cap_a [800];
    int hs_cap_a  [800];
    int cap_c [3][48][80];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, p, h, v, f;
        int pe_err, n_fs, k_fs0, k_y1, first_low, n_low, n_vid, jfs;
        int hs_err, vs_err, vid_err, xy_err, rgb_err, fs_err;
        int fs_k [4];
        int vid_cnt [3];
        int bad_pix;
        logic exp_vid;

        // Mode 1 bars on line 0 of the default raster
        lv[0]  = '{0,   'hFFF, 1, 1};
        lv[1]  = '{79,  'hFFF, 1, 1};
        lv[2]  = '{80,  'hFF0, 1, 1};
        lv[3]  = '{160, 'hF0F, 1, 1};
        lv[4]  = '{239, 'hF0F, 1, 1};
        lv[5]  = '{240, 'hF00, 1, 1};
        lv[6]  = '{320, 'h0FF, 1, 1};
        lv[7]  = '{400, 'h0F0, 1, 1};
        lv[8]  = '{480, 'h00F, 1, 1};
        lv[9]  = '{560, 'h000, 1, 1};
        lv[10] = '{639, 'h000, 1, 1};
        lv[11] = '{640, 'h000, 0, 1};
        lv[12] = '{655, 'h000, 0, 1};
        lv[13] = '{656, 'h000, 0, 0};
        lv[14] = '{751, 'h000, 0, 0};
        lv[15] = '{752, 'h000, 0, 1};

        // Frame 0 solid, frame 1 checker, frame 2 gradient
        fv[0]  = '{0, 63, 39, 'hA5C};
        fv[1]  = '{0, 0,  0,  'hA5C};
        fv[2]  = '{0, 10, 20, 'hA5C};
        fv[3]  = '{1, 32, 0,  'h000};
        fv[4]  = '{1, 0,  0,  'hA5C};
        fv[5]  = '{1, 32, 32, 'hA5C};
        fv[6]  = '{1, 0,  32, 'h000};
        fv[7]  = '{1, 31, 31, 'hA5C};
        fv[8]  = '{2, 40, 20, 'h520};
        fv[9]  = '{2, 63, 39, 'h740};
        fv[10] = '{2, 8,  8,  'h110};
        fv[11] = '{2, 70, 5,  'h000};

        // ---------------- Instance A: reset state ----------------
        mode_a = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        check("a_rst_pix_en", int'(pe_a), 0);
        check("a_rst_hsync", int'(hs_a), 1);
        check("a_rst_vsync", int'(vs_a), 1);
        check("a_rst_video", int'(vid_a), 0);
        check("a_rst_xy", int'({x_a, y_a}), 0);
        check("a_rst_rgb", int'({r_a, g_a, b_a}), 0);
        check("a_rst_frame_start", int'(fs_a), 0);
        rst_a = 1'b0;

        k = 0; p = -1; pe_err = 0; n_fs = 0; k_fs0 = -1; k_y1 = -1;
        while (p < 1900 && k < 8000) begin
            @(posedge clk);
            #1;
            k++;
            if (pe_a !== ((k % 4) == 0)) pe_err++;
            if (fs_a === 1'b1) begin
                n_fs++;
                if (k_fs0 < 0) k_fs0 = k;
            end
            if (vid_a === 1'b1 && y_a == 16'd1 && k_y1 < 0) k_y1 = k;
            if (pe_a === 1'b1) begin
                p++;
                if (p < 800) begin
                    rgb_cap_a[p] = int'({r_a, g_a, b_a});
                    vid_cap_a[p] = int'(vid_a);
                    hs_cap_a[p]  = int'(hs_a);
                end
            end
        end
        check("a_reach_pixel_1900", p, 1900);
        check("a_pix_en_every_4", pe_err, 0);
        check("a_first_frame_start_clk", k_fs0, 4);
        check("a_frame_start_count", n_fs, 1);
        check("a_line_clks", k_y1 - k_fs0, 3200);

        first_low = -1; n_low = 0; n_vid = 0;
        for (int i = 0; i < 800; i++) begin
            if (hs_cap_a[i] == 0) begin
                n_low++;
                if (first_low < 0) first_low = i;
            end
            if (vid_cap_a[i] == 1) n_vid++;
        end
        check("a_hsync_low_pixels", n_low, 96);
        check("a_hsync_first_low_h", first_low, 656);
        check("a_video_pixels_line0", n_vid, 640);

        for (int i = 0; i < 16; i++) begin
            check($sformatf("a_h%0d_rgb", lv[i].h), rgb_cap_a[lv[i].h], lv[i].exp_rgb);
            check($sformatf("a_h%0d_video", lv[i].h), vid_cap_a[lv[i].h], lv[i].exp_video);
            check($sformatf("a_h%0d_hsync", lv[i].h), hs_cap_a[lv[i].h], lv[i].exp_hsync);
        end

        // Mid-line reset (line 2, h=300) then restart from the origin
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        check("a_midrst_pix_en", int'(pe_a), 0);
        check("a_midrst_video", int'(vid_a), 0);
        check("a_midrst_xy", int'({x_a, y_a}), 0);
        check("a_midrst_rgb", int'({r_a, g_a, b_a}), 0);
        check("a_midrst_syncs", int'({hs_a, vs_a}), 3);
        check("a_midrst_frame_start", int'(fs_a), 0);
        rst_a = 1'b0;
        jfs = -1;
        for (int j = 1; j <= 20 && jfs < 0; j++) begin
            @(posedge clk);
            #1;
            if (fs_a === 1'b1) begin
                jfs = j;
                check("a_restart_xy", int'({x_a, y_a}), 0);
                check("a_restart_video", int'(vid_a), 1);
                check("a_restart_rgb", int'({r_a, g_a, b_a}), 'hFFF);
            end
        end
        check("a_restart_fs_clk", jfs, 4);

        // ---------------- Instance B: tiny raster ----------------
        @(posedge clk);
        #1;
        check("b_rst_syncs", int'({hs_b, vs_b}), 0);
        rst_b = 1'b0;
        pe_err = 0; hs_err = 0; vs_err = 0; vid_err = 0; xy_err = 0; rgb_err = 0; fs_err = 0;
        n_fs = 0;
        for (int kk = 1; kk <= 300; kk++) begin
            @(posedge clk);
            #1;
            p = kk - 1;
            h = p % 14;
            v = (p / 14) % 7;
            exp_vid = (h < 8) && (v < 4);
            if (pe_b !== 1'b1) pe_err++;
            if (hs_b !== ((h >= 10) && (h <= 11))) hs_err++;
            if (vs_b !== (v == 5)) vs_err++;
            if (vid_b !== exp_vid) vid_err++;
            if (x_b !== (exp_vid ? 16'(h) : 16'd0) || y_b !== (exp_vid ? 16'(v) : 16'd0)) xy_err++;
            if ({r_b, g_b, b_b} !== (exp_vid ? 12'h123 : 12'h000)) rgb_err++;
            if (fs_b !== ((h == 0) && (v == 0))) fs_err++;
            if (fs_b === 1'b1 && n_fs < 4) begin
                fs_k[n_fs] = kk;
                n_fs++;
            end
        end
        check("b_pix_en_const", pe_err, 0);
        check("b_hsync_h10_11", hs_err, 0);
        check("b_vsync_v5", vs_err, 0);
        check("b_video", vid_err, 0);
        check("b_xy", xy_err, 0);
        check("b_rgb_solid", rgb_err, 0);
        check("b_frame_start_pos", fs_err, 0);
        check("b_fs_count", n_fs, 4);
        check("b_fs_first_clk", fs_k[0], 1);
        check("b_fs_period", fs_k[1] - fs_k[0], 98);

        // ---------------- Instance C: three scaled frames ----------------
        rst_c = 1'b0;
        k = 0; p = -1; n_fs = 0; vs_err = 0; vid_err = 0;
        for (int i = 0; i < 3; i++) vid_cnt[i] = 0;
        while (p < 11519 && k < 24000) begin
            @(posedge clk);
            #1;
            k++;
            if (fs_c === 1'b1 && n_fs < 4) begin
                fs_k[n_fs] = k;
                n_fs++;
            end
            if (pe_c === 1'b1) begin
                p++;
                h = p % 80;
                v = (p / 80) % 48;
                f = p / 3840;
                if (f < 3) begin
                    cap_c[f][v][h] = int'({r_c, g_c, b_c});
                    if (vid_c === 1'b1) vid_cnt[f]++;
                end
                if (vs_c !== !((v == 42) || (v == 43))) vs_err++;
                if (vid_c !== ((h < 64) && (v < 40))) vid_err++;
                if (f == 0 && v == 10 && h == 0) mode_c = 2'd2;
                if (f == 1 && v == 10 && h == 0) mode_c = 2'd3;
            end
        end
        check("c_reach_last_pixel", p, 11519);
        check("c_vsync_v42_43", vs_err, 0);
        check("c_video_window", vid_err, 0);
        check("c_video_pixels_f0", vid_cnt[0], 2560);
        check("c_video_pixels_f1", vid_cnt[1], 2560);
        check("c_fs_count", n_fs, 3);
        check("c_fs_period_0", fs_k[1] - fs_k[0], 7680);
        check("c_fs_period_1", fs_k[2] - fs_k[1], 7680);

        bad_pix = 0;
        for (int vv = 0; vv < 40; vv++)
            for (int hh = 0; hh < 64; hh++)
                if (cap_c[0][vv][hh] != 'hA5C) bad_pix++;
        check("c_f0_mode_held_solid", bad_pix, 0);

        for (int i = 0; i < 12; i++) begin
            check($sformatf("c_f%0d_x%0d_y%0d_rgb", fv[i].f, fv[i].h, fv[i].v),
                  cap_c[fv[i].f][fv[i].v][fv[i].h], fv[i].exp_rgb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_core.md
VGA_TIMING_CORE -- requirements
Module: vga_timing_core

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  CLK_DIV, 4, clk cycles per pixel (>=1)
  H_ACTIVE, 640, visible pixels per line
  H_FP, 16, horizontal front porch
  H_SYNC, 96, horizontal sync width
  H_BP, 48, horizontal back porch
  V_ACTIVE, 480, visible lines
  V_FP, 10, vertical front porch
  V_SYNC, 2, vertical sync width
  V_BP, 33, vertical back porch
  H_POL, 0, asserted hsync level
  V_POL, 0, asserted vsync level
  COLOR_W, 4, bits per colour channel
  CNT_W, 16, x/y output width
REQ-002 Ports, one per line: name direction width meaning.
  clk in 1 system clock, single clock domain
  rst in 1 reset, synchronous, active-high
  mode in 2 pattern select
  fg in 3*COLOR_W solid/checker colour {r,g,b}
  pix_en out 1 pixel-rate strobe
  hsync out 1 horizontal sync
  vsync out 1 vertical sync
  video out 1 active-area flag
  x out CNT_W active column
  y out CNT_W active row
  red/green/blue out COLOR_W each colour channels
  frame_start out 1 first-pixel-of-frame pulse

Function
REQ-003 Divider counts 0..CLK_DIV-1; pix_en high for exactly one clk when count = CLK_DIV-1; CLK_DIV=1 gives pix_en constantly high.
REQ-004 h counter advances only on pix_en, 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP), wraps to 0.
REQ-005 v counter advances on the pix_en where h wraps, 0..V_TOTAL-1, wraps to 0 together with h.
REQ-006 video = (h < H_ACTIVE) and (v < V_ACTIVE); x = h, y = v while video, else x and y hold 0.
REQ-007 hsync = H_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~H_POL; vsync same on v with V_* and V_POL.
REQ-008 All outputs registered, updated only on pix_en, one pixel of latency after counter state, all mutually aligned.
REQ-009 mode latched into internal frame_mode only when counters are at h=0,v=0; mid-frame changes take effect next frame.
REQ-010 Mode 0: rgb = fg.
REQ-011 Mode 1: 8 vertical bars, BAR_W = H_ACTIVE/8, bar k for k*BAR_W <= x < (k+1)*BAR_W, remainder in bar 7; colour code c = 7-k, red/green/blue all-ones when c[2]/c[1]/c[0] set, else 0 (white first, black last).
REQ-012 Mode 2: 32x32 checkerboard; rgb = fg when x[5]^y[5] = 0, else 0.
REQ-013 Mode 3: red = x>>3 truncated to COLOR_W, green = y>>3 truncated, blue = 0.
REQ-014 When video = 0, red/green/blue = 0 regardless of mode.
REQ-015 frame_start high for one clk, on the pix_en cycle presenting pixel (0,0) at the outputs.

Reset
REQ-016 While rst is high at a clk edge: divider, h, v, frame_mode = 0; pix_en, video, frame_start, x, y, rgb = 0; hsync = ~H_POL; vsync = ~V_POL.
REQ-017 Reset mid-line/mid-frame discards the frame; first pix_en after release occurs on the CLK_DIV-th clk, and the frame restarts at (0,0) with a frame_start pulse.

Structure
REQ-018 Shared package vga_pkg holds mode encodings (MODE_SOLID=0, MODE_BARS=1, MODE_CHECK=2, MODE_GRAD=3) and the 640x480@60 timing constants used as defaults.
REQ-019 One sub-module vga_axis_counter (params ACTIVE, FP, SYNC, BP, POL; inputs clk, rst, en; outputs count, wrap, active, sync), instanced once per axis, v instance enabled by pix_en AND h wrap.

Verification
REQ-020 Defaults, rst 3 clk then release -> pix_en every 4 clk; hsync low for 96 pixels starting at h=656; line = 3200 clk.
REQ-021 Defaults, run 2 frames -> frame_start period 1,680,000 clk; vsync low for 2 lines starting at line 490; video high 640x480 pixels per frame.
REQ-022 Mode 1, fg don't-care -> x=0..79 rgb=FFF, x=80 rgb=FF0 (yellow), x=560..639 rgb=000; h=640 rgb=000.
REQ-023 Mode 0 fg=0xA5C, switch mode to 2 at line 100 -> rest of frame stays 0xA5C; next frame (32,0)=000, (0,0)=A5C, (32,32)=A5C.
REQ-024 Small instance CLK_DIV=1, H 8/2/2/2, V 4/1/1/1, H_POL=V_POL=1 -> hsync high h=10..11, vsync high v=5, frame_start every 98 clk.
REQ-025 rst asserted 1 clk at h=300,v=200 -> next edge outputs at reset values; frame_start 4 clk after release with x=0,y=0,video=1.
